// File: rtl/fix_field_tokenizer.sv
`default_nettype none
// ============================================================================
// Module   : fix_field_tokenizer
// Purpose  : Splits a FIX byte stream into tag=value fields, flags header and
//            trailer tags and verifies the trailing checksum field.
// Revision : 1.0  initial release
// ============================================================================
module fix_field_tokenizer #(
    parameter logic [7:0] DELIM         = 8'h7C,
    parameter int         TAG_W         = 32,
    parameter int         TAG_DIGITS    = 9,
    parameter int         MAX_VAL_BYTES = 32,
    parameter int         LEN_W         = $clog2(MAX_VAL_BYTES + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 data_i,
    input  logic                       data_valid_i,
    output logic                       data_ready_o,
    output logic [TAG_W-1:0]           tag_o,
    output logic [8*MAX_VAL_BYTES-1:0] value_o,
    output logic [LEN_W-1:0]           value_len_o,
    output logic                       field_valid_o,
    input  logic                       field_ready_i,
    output logic                       start_of_header_o,
    output logic                       end_of_msg_o,
    output logic                       checksum_ok_o,
    output logic                       error_o
);

    localparam int         c_val_w = 8 * MAX_VAL_BYTES;
    localparam int         c_dig_w = $clog2(TAG_DIGITS + 1);
    localparam logic [7:0] c_equals = 8'h3D;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_TAG         = 3'd1,
        S_VALUE       = 3'd2,
        S_FIELD_START = 3'd3,
        S_SKIP        = 3'd4
    } state_t;

    state_t               r_state;
    logic [TAG_W-1:0]     r_tag;
    logic [c_dig_w-1:0]   r_digits;
    logic [c_val_w-1:0]   r_val;
    logic [LEN_W-1:0]     r_len;
    logic                 r_ovf;
    logic                 r_started;
    logic [7:0]           r_sum8;
    logic [7:0]           r_snap;

    logic [TAG_W-1:0]     r_tag_out;
    logic [c_val_w-1:0]   r_val_out;
    logic [LEN_W-1:0]     r_len_out;
    logic                 r_field_valid;
    logic                 r_sob;
    logic                 r_eom;
    logic                 r_ck_ok;
    logic                 r_error;

    logic                 w_accept;
    logic                 w_is_delim;
    logic                 w_is_equals;
    logic                 w_is_digit;
    logic [3:0]           w_digit;
    logic                 w_start_state;
    logic                 w_sum_add;
    logic                 w_val_full;
    logic [LEN_W-1:0]     w_pad;
    logic [LEN_W+2:0]     w_shift;
    logic [c_val_w-1:0]   w_val_aligned;
    logic                 w_tag_is_10;
    logic                 w_ck_digits;
    logic [9:0]           w_ck_num;
    logic                 w_ck_ok;

    assign data_ready_o  = !rst && !(r_field_valid && !field_ready_i);
    assign w_accept      = data_valid_i && data_ready_o;
    assign w_is_delim    = (data_i == DELIM);
    assign w_is_equals   = (data_i == c_equals);
    assign w_is_digit    = (data_i >= 8'h30) && (data_i <= 8'h39);
    assign w_digit       = data_i[3:0];
    assign w_start_state = (r_state == S_IDLE) || (r_state == S_FIELD_START);
    // Leading delimiters before the first tag digit are not part of the sum.
    assign w_sum_add     = r_started || (w_start_state && w_is_digit);
    assign w_val_full    = (r_len == LEN_W'(MAX_VAL_BYTES));

    // Bytes are shifted in at the LSB end; left-align them for the output.
    assign w_pad         = LEN_W'(MAX_VAL_BYTES) - r_len;
    assign w_shift       = {w_pad, 3'b000};
    assign w_val_aligned = r_val << w_shift;

    assign w_tag_is_10   = (r_tag == TAG_W'(10));
    assign w_ck_digits   = (r_val[23:16] >= 8'h30) && (r_val[23:16] <= 8'h39) &&
                           (r_val[15:8]  >= 8'h30) && (r_val[15:8]  <= 8'h39) &&
                           (r_val[7:0]   >= 8'h30) && (r_val[7:0]   <= 8'h39);
    assign w_ck_num      = 10'(r_val[19:16]) * 10'd100 +
                           10'(r_val[11:8])  * 10'd10  +
                           10'(r_val[3:0]);
    assign w_ck_ok       = (r_len == LEN_W'(3)) && w_ck_digits &&
                           (w_ck_num == {2'b00, r_snap});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_tag         <= '0;
            r_digits      <= '0;
            r_val         <= '0;
            r_len         <= '0;
            r_ovf         <= 1'b0;
            r_started     <= 1'b0;
            r_sum8        <= '0;
            r_snap        <= '0;
            r_tag_out     <= '0;
            r_val_out     <= '0;
            r_len_out     <= '0;
            r_field_valid <= 1'b0;
            r_sob         <= 1'b0;
            r_eom         <= 1'b0;
            r_ck_ok       <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_error <= 1'b0;
            if (r_field_valid && field_ready_i) begin
                r_field_valid <= 1'b0;
            end

            if (w_accept) begin
                if (w_sum_add) begin
                    r_sum8 <= r_sum8 + data_i;
                end

                case (r_state)
                    S_IDLE, S_FIELD_START: begin
                        if (w_is_delim) begin
                            if (r_state == S_FIELD_START) begin
                                r_error <= 1'b1;
                            end
                        end else if (w_is_digit) begin
                            r_tag     <= TAG_W'(w_digit);
                            r_digits  <= c_dig_w'(1);
                            r_snap    <= r_sum8;
                            r_started <= 1'b1;
                            r_val     <= '0;
                            r_len     <= '0;
                            r_ovf     <= 1'b0;
                            r_state   <= S_TAG;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= S_SKIP;
                        end
                    end

                    S_TAG: begin
                        if (w_is_delim) begin
                            r_error <= 1'b1;
                            r_state <= S_FIELD_START;
                        end else if (w_is_digit) begin
                            if (r_digits == c_dig_w'(TAG_DIGITS)) begin
                                r_error <= 1'b1;
                                r_state <= S_SKIP;
                            end else begin
                                r_tag    <= r_tag * TAG_W'(10) + TAG_W'(w_digit);
                                r_digits <= r_digits + c_dig_w'(1);
                            end
                        end else if (w_is_equals) begin
                            r_state <= S_VALUE;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= S_SKIP;
                        end
                    end

                    S_VALUE: begin
                        if (w_is_delim) begin
                            r_tag_out     <= r_tag;
                            r_val_out     <= w_val_aligned;
                            r_len_out     <= r_len;
                            r_field_valid <= 1'b1;
                            r_sob         <= (r_tag == TAG_W'(8));
                            r_eom         <= w_tag_is_10;
                            r_ck_ok       <= w_tag_is_10 && w_ck_ok;
                            r_tag         <= '0;
                            r_digits      <= '0;
                            r_val         <= '0;
                            r_len         <= '0;
                            r_ovf         <= 1'b0;
                            // The trailer closes the message: restart the sum.
                            if (w_tag_is_10) begin
                                r_sum8    <= '0;
                                r_started <= 1'b0;
                                r_state   <= S_IDLE;
                            end else begin
                                r_state   <= S_FIELD_START;
                            end
                        end else if (!w_val_full) begin
                            r_val <= {r_val[c_val_w-9:0], data_i};
                            r_len <= r_len + LEN_W'(1);
                        end else if (!r_ovf) begin
                            r_ovf   <= 1'b1;
                            r_error <= 1'b1;
                        end
                    end

                    S_SKIP: begin
                        if (w_is_delim) begin
                            r_state <= S_FIELD_START;
                        end
                    end

                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign tag_o             = r_tag_out;
    assign value_o           = r_val_out;
    assign value_len_o       = r_len_out;
    assign field_valid_o     = r_field_valid;
    assign start_of_header_o = r_sob;
    assign end_of_msg_o      = r_eom;
    assign checksum_ok_o     = r_ck_ok;
    assign error_o           = r_error;

endmodule
`default_nettype wire

// File: tb/tb_fix_field_tokenizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fix_field_tokenizer
// Purpose  : Scoreboard bench for fix_field_tokenizer using '|' delimiters.
// Revision : 1.0  initial release
// ============================================================================
module tb_fix_field_tokenizer;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   data_i;
    logic         data_valid_i;
    logic         data_ready_o;
    logic [31:0]  tag_o;
    logic [255:0] value_o;
    logic [5:0]   value_len_o;
    logic         field_valid_o;
    logic         field_ready_i;
    logic         start_of_header_o;
    logic         end_of_msg_o;
    logic         checksum_ok_o;
    logic         error_o;

    typedef struct {
        logic [31:0]  tag;
        logic [5:0]   len;
        logic [255:0] val;
        logic         sob;
        logic         eom;
        logic         ck;
    } exp_t;

    exp_t q[$];
    int   n_checks   = 0;
    int   n_errors   = 0;
    int   err_pulses = 0;

    fix_field_tokenizer #(
        .DELIM(8'h7C), .TAG_W(32), .TAG_DIGITS(9), .MAX_VAL_BYTES(32), .LEN_W(6)
    ) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .data_valid_i(data_valid_i),
        .data_ready_o(data_ready_o), .tag_o(tag_o), .value_o(value_o),
        .value_len_o(value_len_o), .field_valid_o(field_valid_o),
        .field_ready_i(field_ready_i), .start_of_header_o(start_of_header_o),
        .end_of_msg_o(end_of_msg_o), .checksum_ok_o(checksum_ok_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: count error pulses and pop the scoreboard on each consumed field.
    always @(negedge clk) begin
        if (error_o) err_pulses++;
        if (!rst && field_valid_o && field_ready_i) begin
            if (q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL unexpected_field: got tag=%0d len=%0d, required no field", tag_o, value_len_o);
            end else begin
                exp_t e;
                e = q.pop_front();
                n_checks++;
                if (tag_o !== e.tag) begin
                    n_errors++;
                    $display("FAIL field_tag: got %0d, required %0d", tag_o, e.tag);
                end
                n_checks++;
                if (value_len_o !== e.len) begin
                    n_errors++;
                    $display("FAIL field_len tag=%0d: got %0d, required %0d", e.tag, value_len_o, e.len);
                end
                n_checks++;
                if (value_o !== e.val) begin
                    n_errors++;
                    $display("FAIL field_value tag=%0d: got %h, required %h", e.tag, value_o, e.val);
                end
                n_checks++;
                if ({start_of_header_o, end_of_msg_o, checksum_ok_o} !== {e.sob, e.eom, e.ck}) begin
                    n_errors++;
                    $display("FAIL field_flags tag=%0d: got sob/eom/ck=%b%b%b, required %b%b%b",
                             e.tag, start_of_header_o, end_of_msg_o, checksum_ok_o, e.sob, e.eom, e.ck);
                end
            end
        end
    end

    task automatic push(input int tag, input string v, input logic sob, input logic eom, input logic ck);
        exp_t e;
        e.tag = tag;
        e.val = '0;
        e.len = (v.len() > 32) ? 6'd32 : 6'(v.len());
        for (int i = 0; i < v.len() && i < 32; i++) e.val[255-8*i -: 8] = v[i];
        e.sob = sob; e.eom = eom; e.ck = ck;
        q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        data_i = b;
        data_valid_i = 1'b1;
        while (!data_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_checks++; n_errors++;
            $display("FAIL send_timeout: data_ready_o=%b, required 1 within 100 cycles", data_ready_o);
        end
        @(posedge clk);
        #1 data_valid_i = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        data_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        err_pulses = 0;
    endtask

    task automatic drain(input string name, input int exp_err);
        int n = 0;
        while (q.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL %s_fields_missing: got %0d pending, required 0", name, q.size());
        end
        n_checks++;
        if (err_pulses != exp_err) begin
            n_errors++;
            $display("FAIL %s_error_pulses: got %0d, required %0d", name, err_pulses, exp_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        data_valid_i = 1'b0;
        data_i = 8'h00;
        field_ready_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({field_valid_o, error_o, data_ready_o, start_of_header_o, end_of_msg_o, checksum_ok_o} !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_flags: got %b, required 000000",
                     {field_valid_o, error_o, data_ready_o, start_of_header_o, end_of_msg_o, checksum_ok_o});
        end
        n_checks++;
        if ({tag_o, value_len_o, value_o} !== '0) begin
            n_errors++;
            $display("FAIL reset_data: got tag=%0d len=%0d, required 0", tag_o, value_len_o);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (data_ready_o !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_ready_after: got %b, required 1", data_ready_o);
        end
    endtask

    task automatic test_basic_message();
        apply_reset();
        push(8, "A", 1'b1, 1'b0, 1'b0);
        push(10, "050", 1'b0, 1'b1, 1'b1);
        send_str("|8=A|10=050|");
        drain("basic", 0);
    endtask

    task automatic test_bad_checksum();
        apply_reset();
        push(8, "A", 1'b1, 1'b0, 1'b0);
        push(10, "051", 1'b0, 1'b1, 1'b0);
        send_str("|8=A|10=051|");
        drain("bad_ck", 0);
    endtask

    task automatic test_backpressure();
        apply_reset();
        field_ready_i = 1'b0;
        push(35, "8", 1'b0, 1'b0, 1'b0);
        send_str("|35=8|");
        repeat (5) begin
            @(negedge clk);
            n_checks++;
            if (field_valid_o !== 1'b1 || tag_o !== 32'd35 || data_ready_o !== 1'b0) begin
                n_errors++;
                $display("FAIL stall_hold: got valid=%b tag=%0d ready=%b, required 1/35/0",
                         field_valid_o, tag_o, data_ready_o);
            end
        end
        @(posedge clk);
        #1;
        field_ready_i = 1'b1;
        data_i = "5";
        data_valid_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if (data_ready_o !== 1'b1) begin
            n_errors++;
            $display("FAIL stall_release_ready: got %b, required 1", data_ready_o);
        end
        @(posedge clk);
        #1 data_valid_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (field_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL stall_release_valid: got %b, required 0", field_valid_o);
        end
        drain("stall", 0);
    endtask

    task automatic test_overflow();
        string xs = "";
        string stim = "|58=";
        for (int i = 0; i < 32; i++) xs = {xs, "X"};
        for (int i = 0; i < 40; i++) stim = {stim, "X"};
        stim = {stim, "|"};
        apply_reset();
        push(58, xs, 1'b0, 1'b0, 1'b0);
        send_str(stim);
        drain("overflow", 1);
    endtask

    task automatic test_malformed();
        apply_reset();
        push(9, "7", 1'b0, 1'b0, 1'b0);
        send_str("|=5|3a=1|9=7|");
        drain("malformed", 2);
    endtask

    task automatic test_reset_mid_field();
        apply_reset();
        send_str("|49=PHL");
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        err_pulses = 0;
        @(negedge clk);
        n_checks++;
        if (field_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_valid: got %b, required 0", field_valid_o);
        end
        push(8, "B", 1'b1, 1'b0, 1'b0);
        push(10, "051", 1'b0, 1'b1, 1'b1);
        send_str("8=B|10=051|");
        drain("midreset", 0);
    endtask

    task automatic test_back_to_back();
        apply_reset();
        push(8, "", 1'b1, 1'b0, 1'b0);
        push(9, "xy", 1'b0, 1'b0, 1'b0);
        push(123456789, "Q", 1'b0, 1'b0, 1'b0);
        send_str("8=|9=xy|123456789=Q|1234567890=Z|");
        drain("b2b", 1);
    endtask

    initial begin
        test_reset();
        test_basic_message();
        test_bad_checksum();
        test_backpressure();
        test_overflow();
        test_malformed();
        test_reset_mid_field();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fix_field_tokenizer.md
Name: fix_field_tokenizer

Overview:
- Parametrised successor to the fixed byte-stream front end of fix_parser_top.
- Accepts a FIX byte stream with a valid/ready handshake and splits it into tag=value fields.
- Converts each tag to binary, packs the value bytes MSB-first, flags start of header (tag 8) and end of message (tag 10), and verifies the FIX checksum.
- Sits between the byte source and the field store/decoder; the output is held until the consumer accepts it.

Parameters:
- DELIM, 8'h7C: field delimiter. Use 8'h7C ('|') for the bench and 8'h01 (SOH) for the wire.
- TAG_W, 32: width of the binary tag output.
- TAG_DIGITS, 9: maximum number of decimal digits in a tag.
- MAX_VAL_BYTES, 32: capacity of the value buffer in bytes. value_o is 8*MAX_VAL_BYTES bits wide.
- LEN_W, $clog2(MAX_VAL_BYTES+1): width of value_len_o.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_i  in  8  input byte.
- data_valid_i  in  1  data_i is valid.
- data_ready_o  out  1  byte accepted when data_valid_i && data_ready_o.
- tag_o  out  TAG_W  binary tag of the emitted field.
- value_o  out  8*MAX_VAL_BYTES  value bytes. First byte at [8*MAX_VAL_BYTES-1 -: 8]; unused bytes are zero.
- value_len_o  out  LEN_W  number of value bytes stored (saturates at MAX_VAL_BYTES).
- field_valid_o  out  1  field outputs are valid; held until field_ready_i.
- field_ready_i  in  1  consumer accepts the field.
- start_of_header_o  out  1  qualified by field_valid_o: tag_o==8.
- end_of_msg_o  out  1  qualified by field_valid_o: tag_o==10.
- checksum_ok_o  out  1  qualified by end_of_msg_o: checksum matched.
- error_o  out  1  one-cycle pulse on a malformed field.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - All outputs are 0; data_ready_o is 0 while rst=1.
  - Accumulators are cleared; any partial field is discarded.
- data_ready_o = !rst && !(field_valid_o && !field_ready_i).
  - A new byte may be accepted in the same cycle the pending field is consumed.
- States:
  - IDLE:
    - DELIM is consumed and ignored.
    - A digit becomes the first tag digit; go to TAG.
    - Any other byte pulses error_o; go to SKIP.
  - TAG:
    - A digit updates tag = tag*10 + digit and increments the digit count.
    - '=' with digit count ≥1 goes to VALUE.
    - Any of the following pulses error_o and goes to SKIP:
      - '=' with zero digits.
      - A non-digit other than '='.
      - A digit count exceeding TAG_DIGITS.
    - DELIM in TAG pulses error_o and goes to FIELD_START.
  - VALUE:
    - A non-DELIM byte is stored at index value_len if value_len < MAX_VAL_BYTES; value_len increments.
    - On overflow the byte is dropped, value_len stays at MAX_VAL_BYTES, and error_o pulses once per field.
    - DELIM registers the field: field_valid_o=1 on the next cycle, then go to FIELD_START.
    - A zero-length value is emitted with value_len_o=0.
  - FIELD_START:
    - Same as IDLE, except DELIM is an empty field: pulse error_o and stay.
  - SKIP:
    - Discard bytes until DELIM, then go to FIELD_START.
- Latency: field outputs are registered one cycle after the terminating DELIM is accepted. They stay stable while field_valid_o && !field_ready_i.
- Checksum:
  - sum8 = 8-bit wrapping sum of every accepted byte from the first tag digit of a message through each DELIM. Leading DELIMs skipped in IDLE are excluded.
  - At the first tag digit of every field, snapshot the current sum8.
  - For a tag-10 field, the value must be exactly 3 decimal digits whose number equals the snapshot; otherwise checksum_ok_o=0.
  - After the tag-10 field is registered, clear sum8 and return to IDLE.
- A tag-10 field while error_o fired earlier in the same message still reports checksum_ok_o per the arithmetic.
- Reset asserted mid-field drops the field with no output. Bytes after release start a new message.

Test Plan:
- Reset, then "|8=A|10=050|" streamed with field_ready_i=1 produces:
  - Field tag=8, value_o[MSB byte]=8'h41, len=1, start_of_header_o=1.
  - Field tag=10, len=3, end_of_msg_o=1, checksum_ok_o=1. The byte sum 56+61+65+124=306 gives 50 mod 256.
- Same stream with "10=051" → end_of_msg_o=1, checksum_ok_o=0.
- "|35=8|" with field_ready_i=0 for 5 cycles:
  - field_valid_o=1 with tag=35 held stable and data_ready_o=0.
  - After field_ready_i=1, the next byte is accepted that same cycle.
- "|58=" followed by 40 'X' bytes and '|' → error_o pulses once, value_len_o=32, all 32 bytes are 8'h58, tag=58.
- Malformed stream "|=5|3a=1|9=7|" → two error_o pulses and exactly one field emitted (tag=9, value "7").
- rst pulsed while in VALUE of "|49=PHL" → no field emitted. The following "8=B|" emits tag=8 and its checksum snapshot starts at 0.
